// File: rtl/alu_rsv_station.sv
// alu_rsv_station: integer ALU reservation station.
// Holds dispatched ALU ops until both source operands are present, captures
// missing operands from the CDB, and issues the oldest ready op each cycle
// into the registered ex1 stage feeding int_alu.
// Optional build macro: RS_PERF_CNT_EN adds the rs_stall_cnt output, a
// saturating count of cycles with occupied entries but none ready.
//
// Dispatch handshake: disp_val is a request qualified by !rs_full. A request
// is taken at a rising edge only when disp_val=1, rs_full=0 and flush=0; the
// producer must not raise disp_val while rs_full=1 (such a request is dropped).
module alu_rsv_station #(
  parameter int RS_DEPTH       = 8,
  parameter int DATA_LEN       = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int ROB_SIZE_CLOG  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_val,
  input  logic [ALU_CTRL_WIDTH-1:0] disp_alu_ctrl,
  input  logic [ROB_SIZE_CLOG-1:0]  disp_robid,
  input  logic                      disp_rs1_rdy,
  input  logic [DATA_LEN-1:0]       disp_rs1_data,
  input  logic [ROB_SIZE_CLOG-1:0]  disp_rs1_tag,
  input  logic                      disp_rs2_rdy,
  input  logic [DATA_LEN-1:0]       disp_rs2_data,
  input  logic [ROB_SIZE_CLOG-1:0]  disp_rs2_tag,
  output logic                      rs_full,
  input  logic                      cdb_val,
  input  logic [ROB_SIZE_CLOG-1:0]  cdb_robid,
  input  logic [DATA_LEN-1:0]       cdb_data,
  output logic                      alu_val_ex1,
  output logic [DATA_LEN-1:0]       rs1_ex1,
  output logic [DATA_LEN-1:0]       rs2_ex1,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_ex1,
  output logic [ROB_SIZE_CLOG-1:0]  robid_ex1
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]               rs_stall_cnt
`endif
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  // Entry storage
  logic [RS_DEPTH-1:0]       ent_val;
  logic [ALU_CTRL_WIDTH-1:0] ent_ctrl  [RS_DEPTH];
  logic [ROB_SIZE_CLOG-1:0]  ent_robid [RS_DEPTH];
  logic [RS_DEPTH-1:0]       s1_rdy;
  logic [DATA_LEN-1:0]       s1_data   [RS_DEPTH];
  logic [ROB_SIZE_CLOG-1:0]  s1_tag    [RS_DEPTH];
  logic [RS_DEPTH-1:0]       s2_rdy;
  logic [DATA_LEN-1:0]       s2_data   [RS_DEPTH];
  logic [ROB_SIZE_CLOG-1:0]  s2_tag    [RS_DEPTH];

  // older[i][j] = 1 means entry i was dispatched before entry j.
  // Only meaningful when both entries are valid.
  logic [RS_DEPTH-1:0]       older     [RS_DEPTH];

  logic [RS_DEPTH-1:0]       ent_rdy;
  logic [IDX_W-1:0]          free_idx;
  logic                      free_found;
  logic [IDX_W-1:0]          sel_idx;
  logic                      sel_val;
  logic                      disp_acc;
  logic                      blocked;

  // Dispatch-time operand values after same-cycle CDB capture
  logic                      new_s1_rdy;
  logic [DATA_LEN-1:0]       new_s1_data;
  logic                      new_s2_rdy;
  logic [DATA_LEN-1:0]       new_s2_data;

  assign ent_rdy  = ent_val & s1_rdy & s2_rdy;
  assign rs_full  = &ent_val;
  assign disp_acc = disp_val && !rs_full && !flush;

  // Lowest-index free slot receives the next dispatch
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!ent_val[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  // Oldest-ready select: a ready entry wins if no other ready entry is older
  always_comb begin
    sel_val = 1'b0;
    sel_idx = '0;
    blocked = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (ent_rdy[j] && older[j][i]) blocked = 1'b1;
      end
      if (ent_rdy[i] && !blocked && !sel_val) begin
        sel_val = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Merge a same-cycle CDB broadcast into the operands being dispatched
  always_comb begin
    new_s1_rdy  = disp_rs1_rdy;
    new_s1_data = disp_rs1_data;
    new_s2_rdy  = disp_rs2_rdy;
    new_s2_data = disp_rs2_data;
    if (!disp_rs1_rdy && cdb_val && (cdb_robid == disp_rs1_tag)) begin
      new_s1_rdy  = 1'b1;
      new_s1_data = cdb_data;
    end
    if (!disp_rs2_rdy && cdb_val && (cdb_robid == disp_rs2_tag)) begin
      new_s2_rdy  = 1'b1;
      new_s2_data = cdb_data;
    end
  end

  // Entry state: wakeup, free on issue, allocate on dispatch, age update
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_val <= '0;
      s1_rdy  <= '0;
      s2_rdy  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        older[i] <= '0;
      end
    end else if (flush) begin
      ent_val <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (ent_val[i] && !s1_rdy[i] && cdb_val && (cdb_robid == s1_tag[i])) begin
          s1_rdy[i]  <= 1'b1;
          s1_data[i] <= cdb_data;
        end
        if (ent_val[i] && !s2_rdy[i] && cdb_val && (cdb_robid == s2_tag[i])) begin
          s2_rdy[i]  <= 1'b1;
          s2_data[i] <= cdb_data;
        end
      end
      if (sel_val) begin
        ent_val[sel_idx] <= 1'b0;
      end
      if (disp_acc) begin
        ent_val[free_idx]   <= 1'b1;
        ent_ctrl[free_idx]  <= disp_alu_ctrl;
        ent_robid[free_idx] <= disp_robid;
        s1_rdy[free_idx]    <= new_s1_rdy;
        s1_data[free_idx]   <= new_s1_data;
        s1_tag[free_idx]    <= disp_rs1_tag;
        s2_rdy[free_idx]    <= new_s2_rdy;
        s2_data[free_idx]   <= new_s2_data;
        s2_tag[free_idx]    <= disp_rs2_tag;
        // New entry is younger than every currently valid entry
        older[free_idx]     <= '0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          older[j][free_idx] <= ent_val[j];
        end
      end
    end
  end

  // ex1 issue register: one-cycle valid pulse, data held when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_val_ex1  <= 1'b0;
      rs1_ex1      <= '0;
      rs2_ex1      <= '0;
      alu_ctrl_ex1 <= '0;
      robid_ex1    <= '0;
    end else if (flush) begin
      alu_val_ex1  <= 1'b0;
    end else if (sel_val) begin
      alu_val_ex1  <= 1'b1;
      rs1_ex1      <= s1_data[sel_idx];
      rs2_ex1      <= s2_data[sel_idx];
      alu_ctrl_ex1 <= ent_ctrl[sel_idx];
      robid_ex1    <= ent_robid[sel_idx];
    end else begin
      alu_val_ex1  <= 1'b0;
    end
  end

`ifdef RS_PERF_CNT_EN
  // Saturating stall counter: occupied but nothing ready; survives flush
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_stall_cnt <= '0;
    end else if ((|ent_val) && !(|ent_rdy) && (rs_stall_cnt != 32'hFFFF_FFFF)) begin
      rs_stall_cnt <= rs_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rsv_station.sv
// tb_alu_rsv_station: directed plan scenarios plus randomized traffic,
// compared every cycle against an age-ordered queue model of the station.
module tb_alu_rsv_station;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_val;
  logic [3:0]  disp_alu_ctrl;
  logic [5:0]  disp_robid;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_data, disp_rs2_data;
  logic [5:0]  disp_rs1_tag, disp_rs2_tag;
  logic        rs_full;
  logic        cdb_val;
  logic [5:0]  cdb_robid;
  logic [31:0] cdb_data;
  logic        alu_val_ex1;
  logic [31:0] rs1_ex1, rs2_ex1;
  logic [3:0]  alu_ctrl_ex1;
  logic [5:0]  robid_ex1;
`ifdef RS_PERF_CNT_EN
  logic [31:0] rs_stall_cnt;
`endif

  alu_rsv_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_val(disp_val), .disp_alu_ctrl(disp_alu_ctrl), .disp_robid(disp_robid),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_data(disp_rs1_data), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_data(disp_rs2_data), .disp_rs2_tag(disp_rs2_tag),
    .rs_full(rs_full),
    .cdb_val(cdb_val), .cdb_robid(cdb_robid), .cdb_data(cdb_data),
    .alu_val_ex1(alu_val_ex1), .rs1_ex1(rs1_ex1), .rs2_ex1(rs2_ex1),
    .alu_ctrl_ex1(alu_ctrl_ex1), .robid_ex1(robid_ex1)
`ifdef RS_PERF_CNT_EN
    , .rs_stall_cnt(rs_stall_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;
  bit allow_full = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: pending ops kept oldest-first in a queue
  typedef struct {
    logic [3:0]  ctrl;
    logic [5:0]  robid;
    logic        r1;
    logic [31:0] d1;
    logic [5:0]  t1;
    logic        r2;
    logic [31:0] d2;
    logic [5:0]  t2;
  } ent_t;

  ent_t        mq[$];
  logic        e_val = 1'b0;
  logic [31:0] e_rs1 = '0, e_rs2 = '0;
  logic [3:0]  e_ctrl = '0;
  logic [5:0]  e_robid = '0;
  logic [31:0] exp_q[$];   // expected issue order (robids) from the model

  always @(posedge clk) begin
    ent_t tmp;
    int   idx;
    bit   full;
    if (rst) begin
      mq.delete();
      e_val = 1'b0; e_rs1 = '0; e_rs2 = '0; e_ctrl = '0; e_robid = '0;
    end else if (flush) begin
      mq.delete();
      e_val = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      if (chk_en) chk("no_disp_when_full", {63'd0, disp_val && full && !allow_full}, 64'd0);
      idx = -1;
      for (int k = 0; k < mq.size(); k++)
        if (idx < 0 && mq[k].r1 && mq[k].r2) idx = k;
      if (idx >= 0) begin
        e_val = 1'b1;
        e_rs1 = mq[idx].d1; e_rs2 = mq[idx].d2;
        e_ctrl = mq[idx].ctrl; e_robid = mq[idx].robid;
        exp_q.push_back({26'd0, mq[idx].robid});
        mq.delete(idx);
      end else begin
        e_val = 1'b0;
      end
      if (cdb_val) begin
        for (int k = 0; k < mq.size(); k++) begin
          tmp = mq[k];
          if (!tmp.r1 && tmp.t1 == cdb_robid) begin tmp.r1 = 1'b1; tmp.d1 = cdb_data; end
          if (!tmp.r2 && tmp.t2 == cdb_robid) begin tmp.r2 = 1'b1; tmp.d2 = cdb_data; end
          mq[k] = tmp;
        end
      end
      if (disp_val && !full) begin
        tmp.ctrl = disp_alu_ctrl; tmp.robid = disp_robid;
        tmp.r1 = disp_rs1_rdy; tmp.d1 = disp_rs1_data; tmp.t1 = disp_rs1_tag;
        tmp.r2 = disp_rs2_rdy; tmp.d2 = disp_rs2_data; tmp.t2 = disp_rs2_tag;
        if (!tmp.r1 && cdb_val && cdb_robid == tmp.t1) begin tmp.r1 = 1'b1; tmp.d1 = cdb_data; end
        if (!tmp.r2 && cdb_val && cdb_robid == tmp.t2) begin tmp.r2 = 1'b1; tmp.d2 = cdb_data; end
        mq.push_back(tmp);
      end
    end
  end

  // Scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_val_ex1", {63'd0, alu_val_ex1}, {63'd0, e_val});
      chk("rs1_ex1", {32'd0, rs1_ex1}, {32'd0, e_rs1});
      chk("rs2_ex1", {32'd0, rs2_ex1}, {32'd0, e_rs2});
      chk("alu_ctrl_ex1", {60'd0, alu_ctrl_ex1}, {60'd0, e_ctrl});
      chk("robid_ex1", {58'd0, robid_ex1}, {58'd0, e_robid});
      chk("rs_full", {63'd0, rs_full}, {63'd0, mq.size() == DEPTH});
      if (alu_val_ex1 && exp_q.size() > 0) begin
        chk("issue_order", {58'd0, robid_ex1}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic idle();
    disp_val = 1'b0; cdb_val = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_disp(input logic [3:0] c, input logic [5:0] rid,
                            input logic r1, input logic [31:0] d1, input logic [5:0] t1,
                            input logic r2, input logic [31:0] d2, input logic [5:0] t2);
    disp_val = 1'b1; disp_alu_ctrl = c; disp_robid = rid;
    disp_rs1_rdy = r1; disp_rs1_data = d1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_data = d2; disp_rs2_tag = t2;
  endtask

  task automatic drive_cdb(input logic [5:0] tag, input logic [31:0] d);
    cdb_val = 1'b1; cdb_robid = tag; cdb_data = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit robid_live(input logic [5:0] r);
    for (int k = 0; k < mq.size(); k++) if (mq[k].robid == r) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [5:0] rid;
    rst = 1'b1;
    idle();
    drive_disp(4'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0);
    disp_val = 1'b0;
    cdb_robid = '0; cdb_data = '0;
    tick();
    tick();
    chk("reset_val", {63'd0, alu_val_ex1}, 64'd0);
    chk("reset_full", {63'd0, rs_full}, 64'd0);
    chk("reset_rs1", {32'd0, rs1_ex1}, 64'd0);
    chk("reset_robid", {58'd0, robid_ex1}, 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // Ready dispatch: issue one edge after acceptance
    drive_disp(4'd0, 6'd5, 1'b1, 32'h10, 6'd0, 1'b1, 32'h20, 6'd0);
    tick(); idle();
    chk("rdy_lat_early", {63'd0, alu_val_ex1}, 64'd0);
    tick();
    chk("rdy_val", {63'd0, alu_val_ex1}, 64'd1);
    chk("rdy_rs1", {32'd0, rs1_ex1}, 64'h10);
    chk("rdy_rs2", {32'd0, rs2_ex1}, 64'h20);
    chk("rdy_robid", {58'd0, robid_ex1}, 64'd5);
    tick();
    chk("rdy_pulse", {63'd0, alu_val_ex1}, 64'd0);

    // CDB wakeup
    drive_disp(4'd1, 6'd7, 1'b0, 32'd0, 6'd3, 1'b1, 32'h1, 6'd0);
    tick(); idle(); tick(); tick();
    drive_cdb(6'd3, 32'hDEAD);
    tick(); idle();
    chk("wake_early", {63'd0, alu_val_ex1}, 64'd0);
    tick();
    chk("wake_val", {63'd0, alu_val_ex1}, 64'd1);
    chk("wake_rs1", {32'd0, rs1_ex1}, 64'hDEAD);
    chk("wake_robid", {58'd0, robid_ex1}, 64'd7);

    // Same-cycle capture at dispatch
    drive_disp(4'd2, 6'd8, 1'b1, 32'h77, 6'd0, 1'b0, 32'd0, 6'd9);
    drive_cdb(6'd9, 32'h55);
    tick(); idle(); tick();
    chk("cap_val", {63'd0, alu_val_ex1}, 64'd1);
    chk("cap_rs2", {32'd0, rs2_ex1}, 64'h55);
    chk("cap_robid", {58'd0, robid_ex1}, 64'd8);

    // Oldest first with a shared producer tag
    for (int i = 1; i <= 3; i++) begin
      drive_disp(4'd3, 6'(i), 1'b0, 32'd0, 6'd20, 1'b1, 32'(i), 6'd0);
      tick();
    end
    idle();
    drive_cdb(6'd20, 32'hAB);
    tick(); idle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("old_val", {63'd0, alu_val_ex1}, 64'd1);
      chk("old_robid", {58'd0, robid_ex1}, 64'(i));
    end
    tick();
    chk("old_done", {63'd0, alu_val_ex1}, 64'd0);

    // Full: eight waiting entries, a dropped ninth, then one frees
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(4'd4, 6'(10 + i), 1'b0, 32'd0, 6'(40 + i), 1'b1, 32'(i), 6'd0);
      tick();
    end
    idle();
    chk("full_set", {63'd0, rs_full}, 64'd1);
    allow_full = 1'b1;
    drive_disp(4'd5, 6'd30, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0);
    tick(); idle();
    allow_full = 1'b0;
    chk("full_drop", {63'd0, rs_full}, 64'd1);
    tick();
    chk("full_drop_noissue", {63'd0, alu_val_ex1}, 64'd0);
    drive_cdb(6'd40, 32'h99);
    tick(); idle();
    chk("full_still", {63'd0, rs_full}, 64'd1);
    tick();
    chk("full_issue", {63'd0, alu_val_ex1}, 64'd1);
    chk("full_issue_rs1", {32'd0, rs1_ex1}, 64'h99);
    chk("full_cleared", {63'd0, rs_full}, 64'd0);

    // Flush with four ready entries
    flush = 1'b1;
    tick(); idle();
    chk("flush_empty", {63'd0, rs_full}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive_disp(4'd6, 6'(11 + i), 1'b0, 32'd0, 6'd50, 1'b1, 32'(i), 6'd0);
      tick();
    end
    idle();
    drive_cdb(6'd50, 32'h1234);
    tick(); idle();
    flush = 1'b1;
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      chk("flush_noissue", {63'd0, alu_val_ex1}, 64'd0);
      chk("flush_full", {63'd0, rs_full}, 64'd0);
      tick();
    end

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      rst = 1'b0;
      if (mq.size() < DEPTH && $urandom_range(0, 99) < 55) begin
        do rid = 6'($urandom_range(0, 31)); while (robid_live(rid));
        drive_disp(4'($urandom_range(0, 15)), rid,
                   1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(32, 39)),
                   1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(32, 39)));
      end
      if ($urandom_range(0, 99) < 50) drive_cdb(6'($urandom_range(32, 39)), $urandom);
      if ($urandom_range(0, 199) == 0) flush = 1'b1;
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      tick();
    end
    idle();
    rst = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
